// File: rtl/reaction_led_gen.sv
// reaction_led_gen: countdown, pseudo-random delay and target pattern generator
// for the reaction-time test. Supports several acknowledged rounds per game.
module reaction_led_gen #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int LED_W       = 8,
    parameter int WAIT_SEC    = 3,
    parameter int RAND_MS_MAX = 1023,
    parameter int ROUNDS      = 1,
    parameter int MULTI_HOT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             ack,
    output logic             det_start,
    output logic [LED_W-1:0] led,
    output logic [3:0]       sec_left,
    output logic [7:0]       round_idx,
    output logic             busy,
    output logic             done
);

    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int SEC_W  = $clog2(CLK_HZ);
    localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;

    localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(CLK_HZ - 1);
    localparam logic [MS_W-1:0]  MS_LAST    = MS_W'(MS_CYC - 1);
    localparam logic [15:0]      LFSR_SEED  = 16'hACE1;
    localparam logic [15:0]      LFSR_TAPS  = 16'hB400;
    localparam logic [15:0]      RAND_MASK  = 16'(RAND_MS_MAX);
    localparam logic [7:0]       ROUND_LAST = 8'(ROUNDS - 1);
    localparam logic [3:0]       WAIT_INIT  = 4'(WAIT_SEC);
    localparam logic [7:0]       LED_CNT    = 8'(LED_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_RAND  = 3'd2,
        S_SHOW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One step of the right-shifting Galois LFSR; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Target pattern derived from the current LFSR value.
    function automatic logic [LED_W-1:0] target_pattern(input logic [15:0] v);
        logic [7:0]       idx;
        logic [LED_W-1:0] p;
        idx = 8'd0;
        p   = '0;
        if (MULTI_HOT != 0) begin
            p = v[LED_W-1:0];
            if (p == '0) begin
                p = LED_W'(1'b1);
            end else begin
                p = v[LED_W-1:0];
            end
        end else begin
            idx = v[15:8] % LED_CNT;
            p   = LED_W'(1'b1) << idx;
        end
        return p;
    endfunction

    state_t           state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             det_q, det_d;
    logic [3:0]       sec_left_q, sec_left_d;
    logic [7:0]       round_q, round_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic [15:0]      delay_q, delay_d;
    logic [15:0]      lfsr_q, lfsr_d;

    // Next-state and datapath: restart overrides everything, then per-state behaviour.
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        det_d      = 1'b0;
        sec_left_d = sec_left_q;
        round_d    = round_q;
        sec_cnt_d  = sec_cnt_q;
        ms_cnt_d   = ms_cnt_q;
        delay_d    = delay_q;
        lfsr_d     = lfsr_step(lfsr_q);

        if (restart) begin
            state_d    = S_COUNT;
            sec_left_d = WAIT_INIT;
            round_d    = 8'd0;
            led_d      = '0;
            sec_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    led_d = '0;
                end
                S_COUNT: begin
                    if (sec_cnt_q == SEC_LAST) begin
                        sec_cnt_d = '0;
                        if (sec_left_q <= 4'd1) begin
                            sec_left_d = 4'd0;
                            state_d    = S_RAND;
                            delay_d    = lfsr_q & RAND_MASK;
                            ms_cnt_d   = '0;
                        end else begin
                            sec_left_d = sec_left_q - 4'd1;
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1'b1);
                    end
                end
                S_RAND: begin
                    if (delay_q == 16'd0) begin
                        state_d = S_SHOW;
                        led_d   = target_pattern(lfsr_q);
                        det_d   = 1'b1;
                    end else if (ms_cnt_q == MS_LAST) begin
                        ms_cnt_d = '0;
                        delay_d  = delay_q - 16'd1;
                    end else begin
                        ms_cnt_d = ms_cnt_q + MS_W'(1'b1);
                    end
                end
                S_SHOW: begin
                    if (ack) begin
                        led_d = '0;
                        if (round_q < ROUND_LAST) begin
                            round_d  = round_q + 8'd1;
                            state_d  = S_RAND;
                            delay_d  = lfsr_q & RAND_MASK;
                            ms_cnt_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        led_d = led_q;
                    end
                end
                S_DONE: begin
                    led_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    led_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            led_q      <= '0;
            det_q      <= 1'b0;
            sec_left_q <= 4'd0;
            round_q    <= 8'd0;
            sec_cnt_q  <= '0;
            ms_cnt_q   <= '0;
            delay_q    <= 16'd0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            det_q      <= det_d;
            sec_left_q <= sec_left_d;
            round_q    <= round_d;
            sec_cnt_q  <= sec_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            delay_q    <= delay_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign det_start = det_q;
    assign led       = led_q;
    assign sec_left  = sec_left_q;
    assign round_idx = round_q;
    assign busy      = (state_q == S_COUNT) || (state_q == S_RAND) || (state_q == S_SHOW);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_reaction_led_gen.sv
// Directed testbench for reaction_led_gen: three instances (one-hot single round,
// three rounds, multi-hot on 4 LEDs) checked against a cycle-exact LFSR model.
module tb_reaction_led_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic restart_a, restart_b, restart_c;
    logic ack_a, ack_b, ack_c;
    logic det_a, det_b, det_c;
    logic [7:0] led_a, led_b;
    logic [3:0] led_c;
    logic [3:0] sec_a, sec_b, sec_c;
    logic [7:0] rnd_a, rnd_b, rnd_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;

    int n_tests = 0;
    int n_fail  = 0;

    reaction_led_gen #(.CLK_HZ(4000), .LED_W(8), .WAIT_SEC(2), .RAND_MS_MAX(7),
                       .ROUNDS(1), .MULTI_HOT(0)) dut_a (
        .clk(clk), .rst_n(rst_a), .restart(restart_a), .ack(ack_a),
        .det_start(det_a), .led(led_a), .sec_left(sec_a), .round_idx(rnd_a),
        .busy(busy_a), .done(done_a));

    reaction_led_gen #(.CLK_HZ(4000), .LED_W(8), .WAIT_SEC(2), .RAND_MS_MAX(7),
                       .ROUNDS(3), .MULTI_HOT(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .restart(restart_b), .ack(ack_b),
        .det_start(det_b), .led(led_b), .sec_left(sec_b), .round_idx(rnd_b),
        .busy(busy_b), .done(done_b));

    reaction_led_gen #(.CLK_HZ(4000), .LED_W(4), .WAIT_SEC(2), .RAND_MS_MAX(7),
                       .ROUNDS(1), .MULTI_HOT(1)) dut_c (
        .clk(clk), .rst_n(rst_c), .restart(restart_c), .ack(ack_c),
        .det_start(det_c), .led(led_c), .sec_left(sec_c), .round_idx(rnd_c),
        .busy(busy_c), .done(done_c));

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] mdl_a, mdl_b, mdl_c;

    // LFSR model for instance a.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) mdl_a <= 16'hACE1;
        else        mdl_a <= lfsr_step(mdl_a);
    end

    // LFSR model for instance b.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) mdl_b <= 16'hACE1;
        else        mdl_b <= lfsr_step(mdl_b);
    end

    // LFSR model for instance c.
    always @(posedge clk or negedge rst_c) begin
        if (!rst_c) mdl_c <= 16'hACE1;
        else        mdl_c <= lfsr_step(mdl_c);
    end

    function automatic logic [15:0] mdl_of(input int s);
        case (s)
            0:       return mdl_a;
            1:       return mdl_b;
            default: return mdl_c;
        endcase
    endfunction

    function automatic logic [7:0] led_of(input int s);
        case (s)
            0:       return led_a;
            1:       return led_b;
            default: return {4'h0, led_c};
        endcase
    endfunction

    function automatic logic det_of(input int s);
        case (s)
            0:       return det_a;
            1:       return det_b;
            default: return det_c;
        endcase
    endfunction

    function automatic logic [3:0] sec_of(input int s);
        case (s)
            0:       return sec_a;
            1:       return sec_b;
            default: return sec_c;
        endcase
    endfunction

    function automatic logic [7:0] rnd_of(input int s);
        case (s)
            0:       return rnd_a;
            1:       return rnd_b;
            default: return rnd_c;
        endcase
    endfunction

    function automatic logic busy_of(input int s);
        case (s)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic done_of(input int s);
        case (s)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // Expected target from the LFSR value present at the SHOW-entry edge.
    function automatic logic [7:0] exp_pattern(input int s, input logic [15:0] m);
        logic [7:0] p;
        if (s == 2) begin
            p = {4'h0, m[3:0]};
            if (p == 8'h00) p = 8'h01;
        end else begin
            p = 8'h01 << (m[15:8] % 8'd8);
        end
        return p;
    endfunction

    task automatic set_in(input int s, input logic r, input logic a);
        case (s)
            0:       begin restart_a = r; ack_a = a; end
            1:       begin restart_b = r; ack_b = a; end
            default: begin restart_c = r; ack_c = a; end
        endcase
    endtask

    // Drive restart/ack for the edge following the current negedge.
    task automatic pulse(input int s, input logic r, input logic a);
        set_in(s, r, a);
        @(negedge clk);
        set_in(s, 1'b0, 1'b0);
    endtask

    // Starts just after E0; ends just after RAND entry, returning the loaded delay.
    task automatic run_countdown(input int s, output logic [15:0] d);
        n_tests++;
        if (sec_of(s) !== 4'd2 || busy_of(s) !== 1'b1 || led_of(s) !== 8'h00 || det_of(s) !== 1'b0) begin
            n_fail++;
            $display("FAIL cd_start[%0d]: sec=%0d busy=%b led=%h det=%b, want 2 1 00 0",
                     s, sec_of(s), busy_of(s), led_of(s), det_of(s));
        end
        repeat (3999) @(negedge clk);
        n_tests++;
        if (sec_of(s) !== 4'd2) begin
            n_fail++; $display("FAIL cd_3999[%0d]: sec=%0d want 2", s, sec_of(s));
        end
        @(negedge clk);
        n_tests++;
        if (sec_of(s) !== 4'd1) begin
            n_fail++; $display("FAIL cd_4000[%0d]: sec=%0d want 1", s, sec_of(s));
        end
        repeat (3999) @(negedge clk);
        n_tests++;
        if (sec_of(s) !== 4'd1 || busy_of(s) !== 1'b1) begin
            n_fail++; $display("FAIL cd_7999[%0d]: sec=%0d busy=%b want 1 1", s, sec_of(s), busy_of(s));
        end
        d = mdl_of(s) & 16'h0007;
        @(negedge clk);
        n_tests++;
        if (sec_of(s) !== 4'd0 || busy_of(s) !== 1'b1 || led_of(s) !== 8'h00) begin
            n_fail++;
            $display("FAIL cd_rand[%0d]: sec=%0d busy=%b led=%h want 0 1 00", s, sec_of(s), busy_of(s), led_of(s));
        end
    endtask

    // Starts just after RAND entry with delay d; ends one cycle after SHOW entry.
    task automatic run_show(input int s, input int d);
        logic [7:0] pat;
        bit early;
        early = 1'b0;
        for (int i = 0; i < 4 * d; i++) begin
            if (det_of(s) !== 1'b0 || led_of(s) !== 8'h00) early = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (early || det_of(s) !== 1'b0 || led_of(s) !== 8'h00) begin
            n_fail++;
            $display("FAIL show_early[%0d]: early=%b det=%b led=%h want 0 0 00", s, early, det_of(s), led_of(s));
        end
        pat = exp_pattern(s, mdl_of(s));
        @(negedge clk);
        n_tests++;
        if (det_of(s) !== 1'b1 || led_of(s) !== pat) begin
            n_fail++;
            $display("FAIL show_entry[%0d]: det=%b led=%h want 1 %h (d=%0d)", s, det_of(s), led_of(s), pat, d);
        end
        @(negedge clk);
        n_tests++;
        if (det_of(s) !== 1'b0 || led_of(s) !== pat || busy_of(s) !== 1'b1) begin
            n_fail++;
            $display("FAIL show_hold[%0d]: det=%b led=%h busy=%b want 0 %h 1", s, det_of(s), led_of(s), busy_of(s), pat);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_tests++;
            if (led_of(s) !== 8'h00 || det_of(s) !== 1'b0 || sec_of(s) !== 4'd0 ||
                rnd_of(s) !== 8'd0 || busy_of(s) !== 1'b0 || done_of(s) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: led=%h det=%b sec=%0d rnd=%0d busy=%b done=%b want all 0",
                         s, led_of(s), det_of(s), sec_of(s), rnd_of(s), busy_of(s), done_of(s));
            end
        end
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_game();
        logic [15:0] d;
        pulse(0, 1'b1, 1'b0);
        run_countdown(0, d);
        run_show(0, int'(d));
    endtask

    // Restart mid-SHOW timed so the new game draws a zero delay.
    task automatic test_delay_zero();
        logic [15:0] f, d;
        bit found;
        found = 1'b0;
        f = mdl_a;
        for (int i = 0; i < 8000; i++) f = lfsr_step(f);
        for (int k = 0; k < 400 && !found; k++) begin
            if ((f & 16'h0007) == 16'h0000) found = 1'b1;
            else begin
                @(negedge clk);
                f = lfsr_step(f);
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL dz_search: no zero delay within 400 cycles, want one");
        end
        pulse(0, 1'b1, 1'b0);
        run_countdown(0, d);
        run_show(0, int'(d));
    endtask

    task automatic test_restart_cases();
        logic [15:0] d;
        pulse(0, 1'b1, 1'b1);
        n_tests++;
        if (sec_a !== 4'd2 || led_a !== 8'h00 || done_a !== 1'b0 || busy_a !== 1'b1 || rnd_a !== 8'd0) begin
            n_fail++;
            $display("FAIL restart_ack: sec=%0d led=%h done=%b busy=%b rnd=%0d want 2 00 0 1 0",
                     sec_a, led_a, done_a, busy_a, rnd_a);
        end
        pulse(0, 1'b0, 1'b1);
        n_tests++;
        if (sec_a !== 4'd2 || done_a !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++; $display("FAIL ack_in_count: sec=%0d done=%b busy=%b want 2 0 1", sec_a, done_a, busy_a);
        end
        repeat (1998) @(negedge clk);
        pulse(0, 1'b1, 1'b0);
        run_countdown(0, d);
        repeat (4 * int'(d)) @(negedge clk);
        pulse(0, 1'b1, 1'b0);
        n_tests++;
        if (det_a !== 1'b0 || led_a !== 8'h00 || sec_a !== 4'd2 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_at_entry: det=%b led=%h sec=%0d busy=%b want 0 00 2 1", det_a, led_a, sec_a, busy_a);
        end
    endtask

    task automatic test_rounds();
        logic [15:0] d;
        pulse(1, 1'b1, 1'b0);
        run_countdown(1, d);
        run_show(1, int'(d));
        n_tests++;
        if (rnd_b !== 8'd0) begin
            n_fail++; $display("FAIL round0: rnd=%0d want 0", rnd_b);
        end
        for (int r = 1; r < 3; r++) begin
            d = mdl_b & 16'h0007;
            pulse(1, 1'b0, 1'b1);
            n_tests++;
            if (led_b !== 8'h00 || rnd_b !== 8'(r) || sec_b !== 4'd0 || busy_b !== 1'b1 || done_b !== 1'b0) begin
                n_fail++;
                $display("FAIL round_ack%0d: led=%h rnd=%0d sec=%0d busy=%b done=%b want 00 %0d 0 1 0",
                         r, led_b, rnd_b, sec_b, busy_b, done_b, r);
            end
            run_show(1, int'(d));
        end
        pulse(1, 1'b0, 1'b1);
        n_tests++;
        if (done_b !== 1'b1 || led_b !== 8'h00 || busy_b !== 1'b0 || rnd_b !== 8'd2) begin
            n_fail++;
            $display("FAIL rounds_done: done=%b led=%h busy=%b rnd=%0d want 1 00 0 2", done_b, led_b, busy_b, rnd_b);
        end
        pulse(1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        pulse(1, 1'b0, 1'b1);
        n_tests++;
        if (done_b !== 1'b1 || led_b !== 8'h00 || det_b !== 1'b0 || rnd_b !== 8'd2) begin
            n_fail++;
            $display("FAIL done_sticky: done=%b led=%h det=%b rnd=%0d want 1 00 0 2", done_b, led_b, det_b, rnd_b);
        end
    endtask

    task automatic test_multi_hot_reset();
        logic [15:0] d;
        pulse(2, 1'b1, 1'b0);
        run_countdown(2, d);
        run_show(2, int'(d));
        pulse(2, 1'b0, 1'b1);
        n_tests++;
        if (done_c !== 1'b1 || led_c !== 4'h0) begin
            n_fail++; $display("FAIL mh_done: done=%b led=%h want 1 0", done_c, led_c);
        end
        pulse(2, 1'b1, 1'b0);
        run_countdown(2, d);
        #1;
        rst_c = 1'b0;
        #1;
        n_tests++;
        if (led_c !== 4'h0 || det_c !== 1'b0 || sec_c !== 4'd0 || rnd_c !== 8'd0 ||
            busy_c !== 1'b0 || done_c !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: led=%h det=%b sec=%0d rnd=%0d busy=%b done=%b want all 0",
                     led_c, det_c, sec_c, rnd_c, busy_c, done_c);
        end
        repeat (3) @(negedge clk);
        rst_c = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy_c !== 1'b0 || done_c !== 1'b0 || led_c !== 4'h0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b led=%h want 0 0 0", busy_c, done_c, led_c);
        end
        pulse(2, 1'b1, 1'b0);
        run_countdown(2, d);
        run_show(2, int'(d));
    endtask

    initial begin
        test_reset();
        test_basic_game();
        test_delay_zero();
        test_restart_cases();
        test_rounds();
        test_multi_hot_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_led_gen.md
# reaction_led_gen

Parametrised stimulus generator for the reaction-time test. After a start/restart it runs a fixed countdown of whole seconds, then waits a pseudo-random number of milliseconds. It then lights a pseudo-random LED pattern and pulses `det_start` to the reaction detector. It supports multiple rounds per game, with the detector acknowledging each round, and sits between the key-debounce logic (`restart`) and the detector/scoring logic (`det_start`, `ack`).

## Interface
- `CLK_HZ`, 50_000_000: clock frequency. Must be a multiple of 1000.
- `LED_W`, 8: LED count, legal range 2..16.
- `WAIT_SEC`, 3: countdown length in seconds, legal range 1..15.
- `RAND_MS_MAX`, 1023: random-delay mask. Must be 2^k-1 with k ≤ 16.
- `ROUNDS`, 1: rounds per game, legal range 1..255.
- `MULTI_HOT`, 0: 0 = one-hot target; 1 = random multi-hot target.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `restart`, in, 1: start/restart request, sampled each cycle, synchronous active-high.
- `ack`, in, 1: detector finished the current round. Single-cycle pulse, honoured only in SHOW.
- `det_start`, out, 1: one-cycle pulse, coincident with the first cycle `led` shows the target.
- `led`, out, LED_W: target pattern. 0 when no target is shown.
- `sec_left`, out, 4: seconds remaining in the countdown. 0 outside COUNT.
- `round_idx`, out, 8: current round, 0-based.
- `busy`, out, 1: high in COUNT, RAND and SHOW.
- `done`, out, 1: high in DONE.

## Operation
- States: IDLE, COUNT, RAND, SHOW, DONE.
- Reset values: state IDLE, `led`=0, `det_start`=0, `sec_left`=0, `round_idx`=0, `busy`=0, `done`=0, all prescalers 0, LFSR=16'hACE1.
- LFSR: 16-bit Galois, right-shift, taps 16'hB400.
  - Advances every clock from reset.
  - Not affected by `restart`; it never reaches 0.
- `restart` is accepted in every state, including mid-countdown and mid-SHOW, and has priority over `ack` and over every internal transition. On acceptance:
  - state → COUNT
  - `sec_left`=WAIT_SEC
  - `round_idx`=0
  - `led`=0, `det_start`=0
  - second prescaler cleared
- COUNT:
  - The second prescaler counts 0..CLK_HZ-1; a tick occurs when it equals CLK_HZ-1.
  - Each tick decrements `sec_left`.
  - On the tick where `sec_left`=1: `sec_left`→0, state → RAND, D = LFSR & RAND_MS_MAX loaded into a delay counter, ms prescaler cleared.
- RAND:
  - The ms prescaler counts 0..CLK_HZ/1000-1. Each ms tick decrements the delay counter.
  - In any cycle where the delay counter is 0, the next edge performs SHOW entry: state → SHOW, `led`=pattern, `det_start`=1 for that one cycle.
- Pattern (taken from the LFSR value at the SHOW-entry edge):
  - MULTI_HOT=0: one-hot, bit index = LFSR[15:8] mod LED_W.
  - MULTI_HOT=1: LFSR[LED_W-1:0]; if that is zero, 1 is used instead.
- SHOW: `led` holds its value until `ack` or `restart`.
  - `ack` with `round_idx` < ROUNDS-1: `round_idx`+1, `led`=0, state → RAND with a new D loaded and the ms prescaler cleared. There is no second countdown.
  - `ack` with `round_idx` = ROUNDS-1: `led`=0, state → DONE.
- DONE: `done`=1, `led`=0. Leaves only on `restart`.
- `ack` outside SHOW is ignored.

## Timing
- All outputs are registered.
- `busy` and `done` are decoded from the registered state.
- Let E0 be the edge at which `restart` is sampled high:
  - `sec_left` equals WAIT_SEC-k after edge E0 + k·CLK_HZ.
  - RAND is entered at edge E = E0 + WAIT_SEC·CLK_HZ.
- SHOW entry occurs at edge E + D·(CLK_HZ/1000) + 1. For D=0 that is edge E+1.
- `det_start` is high exactly one cycle, starting at the SHOW-entry edge.
- `ack` sampled at edge A: `led` is 0 from edge A. The next round's RAND starts at A, so its SHOW entry is at A + D'·(CLK_HZ/1000) + 1.
- `restart` and `ack` high in the same cycle: `restart` behaviour only.
- `restart` in the same cycle as the SHOW-entry condition: no `det_start`, `led` stays 0.
- Mid-operation `rst_n` assertion: outputs go to reset values immediately (asynchronous). Operation resumes in IDLE after deassertion.

## Test plan
- Bench parameters: CLK_HZ=4000, LED_W=8, WAIT_SEC=2, RAND_MS_MAX=7, ROUNDS=1. The bench carries a cycle-exact LFSR model.
- Basic game: reset, then `restart` pulse at E0.
  - `sec_left` reads 2 → 1 → 0 at E0, E0+4000, E0+8000.
  - SHOW entry at E0+8000+4·D+1.
  - One `det_start` pulse.
  - `led` equals the one-hot of model LFSR[15:8] mod 8.
- Delay-zero case: force a restart timing where the model gives D=0 → SHOW entry exactly 1 cycle after RAND entry.
- Restart mid-SHOW and mid-COUNT: `led`=0 and `sec_left`=2 on the next cycle, and the countdown restarts a full 8000 cycles. With `restart`+`ack` together → no DONE, COUNT restarted.
- ROUNDS=3: `ack` three times → `round_idx` 0,1,2; three `det_start` pulses; no countdown between rounds; `done`=1 and `led`=0 after the third `ack`. Further `ack` pulses have no effect.
- MULTI_HOT=1 with LED_W=4: `led` equals model LFSR[3:0], or 4'b0001 when that is zero. Also assert `rst_n` low mid-RAND → all outputs at reset values asynchronously, state IDLE.
